piranha_hit_ctrl: RTL and testbench
===================================

// Module: piranha_hit_ctrl
// PURPOSE
//  Downstream consumer of the piranha plant position block: decides when Mario touches the plant.
//  Applies the damage, the lives count and the post-hit invulnerability window.
//  Runs on the single system clock Clk; frame_clk is only sampled as a data input to form a one-Clk frame tick.
//  Feeds the game-state/colour logic (mario_hit, lives, blink, game_over).
// PARAMETERS
//  PIR_HW        9    piranha half-width  (sprite 18 wide, centred on piranha_X_Pos)
//  PIR_HH        18   piranha half-height (sprite 36 tall, centred on piranha_Y_Pos)
//  MARIO_HW      8    Mario half-width
//  MARIO_HH      16   Mario half-height
//  PARK_X        800  piranha_X_Pos value meaning "parked off-screen"
//  START_LIVES   3    lives loaded at reset (1..7)
//  INVULN_FRAMES 120  frame ticks of invulnerability after a hit (1..255)
// PORTS
//  Clk               in   1   system clock
//  Reset             in   1   asynchronous, active-low reset
//  frame_clk         in   1   vsync-rate strobe, asynchronous to Clk, sampled only
//  mario_x, mario_y  in   10  Mario centre position
//  piranha_X_Pos     in   10  piranha centre X from the position block
//  piranha_Y_Pos     in   10  piranha centre Y from the position block
//  piranha_health    in   1   1 = plant alive/harmful
//  level_num         in   3   current room
//  piranha_level_num in   3   room the plant lives in
//  mario_hit         out  1   one-Clk pulse on each accepted hit
//  lives             out  3   remaining lives
//  invuln            out  1   1 while in the invulnerability window
//  blink             out  1   invuln & inv_cnt[3]; Mario sprite is hidden when 1
//  game_over         out  1   sticky until reset
// BEHAVIOUR
//  Reset (async, Reset==0): state=IDLE, lives=START_LIVES, mario_hit=0, invuln=0, blink=0, game_over=0,
//    inv_cnt=0, sync flops=0.
//  Frame tick: frame_clk passes through a 2-flop synchroniser s1->s2, then a third flop s3.
//    tick = s2 & ~s3: exactly one Clk cycle per frame_clk rising edge.
//    tick occurs 3 Clk edges after frame_clk rises, at most.
//  Overlap (combinational, signed 11-bit arithmetic):
//    dx = mario_x - piranha_X_Pos; dy = mario_y - piranha_Y_Pos.
//    ovl = |dx| <= PIR_HW+MARIO_HW && |dy| <= PIR_HH+MARIO_HH && piranha_health
//          && level_num==piranha_level_num && piranha_X_Pos!=PARK_X.
//    Bounds are inclusive; touching edges counts as a hit.
//  FSM (registered, Clk):
//    IDLE:   tick & ovl -> HIT. Otherwise stay.
//    HIT:    lasts 1 cycle; mario_hit=1.
//            If lives==1: lives<=0 -> DEAD.
//            Else: lives<=lives-1, inv_cnt<=0 -> INVULN.
//    INVULN: invuln=1; inv_cnt increments on each tick.
//            When a tick arrives with inv_cnt==INVULN_FRAMES-1 -> IDLE.
//            Overlap is ignored in this state.
//    DEAD:   game_over=1, invuln=0; terminal until Reset.
//  Outputs mario_hit, invuln, game_over are decoded from registered state (glitch-free).
//  Latency: tick with ovl -> mario_hit high in the next cycle; lives updates on the same edge that
//    leaves HIT.
//  Boundaries:
//    lives never underflows (HIT with lives==1 goes to DEAD).
//    Overlap without a tick never triggers a hit.
//    Room change during INVULN does not shorten the window.
//    Reset mid-window aborts it immediately.
// TESTING
//  T1 reset: Reset=0 -> lives=3, all flags 0; release, no overlap for 10 frames -> no change.
//  T2 hit: mario(100,435), piranha(100,435), levels equal, health=1, frame_clk edge
//     -> one mario_hit pulse within 4 Clk; lives=2; invuln=1.
//  T3 window: hold overlap for 119 ticks after the hit -> no further hit.
//     After the 120th tick -> IDLE; next tick -> hit, lives=1.
//  T4 edge/guards: dx=17 -> hit; dx=18 -> none.
//     PARK_X position, health=0 or level mismatch with full overlap -> none.
//  T5 death: from lives=1, hit -> lives=0, game_over=1, sticky over 50 ticks; Reset -> lives=3.
//  T6 async reset mid-INVULN (random Clk phase): all outputs at reset values before the next Clk edge.

Source files
------------

// File: rtl/piranha_hit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : piranha_hit_ctrl_if
// Brief    : Position/status bundle into the piranha hit controller and the
//            hit/lives/invulnerability results coming back out of it.
// Revision : 1.0 - initial release
// ============================================================================
interface piranha_hit_ctrl_if;
   logic [9:0] mario_x;
   logic [9:0] mario_y;
   logic [9:0] piranha_X_Pos;
   logic [9:0] piranha_Y_Pos;
   logic       piranha_health;
   logic [2:0] level_num;
   logic [2:0] piranha_level_num;
   logic       mario_hit;
   logic [2:0] lives;
   logic       invuln;
   logic       blink;
   logic       game_over;

   // Producer of positions, consumer of the hit results
   modport master (
      output mario_x, mario_y, piranha_X_Pos, piranha_Y_Pos,
      output piranha_health, level_num, piranha_level_num,
      input  mario_hit, lives, invuln, blink, game_over
   );

   // The hit controller itself
   modport slave (
      input  mario_x, mario_y, piranha_X_Pos, piranha_Y_Pos,
      input  piranha_health, level_num, piranha_level_num,
      output mario_hit, lives, invuln, blink, game_over
   );
endinterface
`default_nettype wire

// File: rtl/piranha_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : piranha_hit_ctrl
// Brief    : Detects Mario touching the piranha plant on frame ticks, applies
//            damage, tracks lives and runs the post-hit invulnerability window.
// Revision : 1.0 - initial release
// ============================================================================
module piranha_hit_ctrl #(
   parameter int PIR_HW        = 9,
   parameter int PIR_HH        = 18,
   parameter int MARIO_HW      = 8,
   parameter int MARIO_HH      = 16,
   parameter int PARK_X        = 800,
   parameter int START_LIVES   = 3,
   parameter int INVULN_FRAMES = 120
) (
   input  wire logic           Clk,
   input  wire logic           Reset,
   input  wire logic           frame_clk,
   piranha_hit_ctrl_if.slave   bus
);

   localparam logic [10:0] c_X_LIM    = 11'(PIR_HW + MARIO_HW);
   localparam logic [10:0] c_Y_LIM    = 11'(PIR_HH + MARIO_HH);
   localparam logic [9:0]  c_PARK_X   = 10'(PARK_X);
   localparam logic [2:0]  c_LIVES0   = 3'(START_LIVES);
   localparam logic [7:0]  c_INV_LAST = 8'(INVULN_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HIT    = 2'd1,
      S_INVULN = 2'd2,
      S_DEAD   = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_lives;
   logic [2:0] w_lives_nxt;
   logic [7:0] r_inv_cnt;
   logic [7:0] w_inv_cnt_nxt;

   logic       r_s1;
   logic       r_s2;
   logic       r_s3;
   logic       w_tick;

   logic [10:0] w_dx;
   logic [10:0] w_dy;
   logic [10:0] w_adx;
   logic [10:0] w_ady;
   logic        w_ovl;

   // Synchronise frame_clk into the Clk domain and keep one more stage for edge detect
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= frame_clk;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_tick = r_s2 & ~r_s3;

   // Signed distance between centres; zero-extended operands give a two's-complement 11-bit result
   always_comb begin
      w_dx  = {1'b0, bus.mario_x} - {1'b0, bus.piranha_X_Pos};
      w_dy  = {1'b0, bus.mario_y} - {1'b0, bus.piranha_Y_Pos};
      w_adx = w_dx[10] ? (~w_dx + 11'd1) : w_dx;
      w_ady = w_dy[10] ? (~w_dy + 11'd1) : w_dy;
      w_ovl = (w_adx <= c_X_LIM) && (w_ady <= c_Y_LIM) && bus.piranha_health
              && (bus.level_num == bus.piranha_level_num)
              && (bus.piranha_X_Pos != c_PARK_X);
   end

   // State, lives and window counter registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_lives   <= c_LIVES0;
         r_inv_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_lives   <= w_lives_nxt;
         r_inv_cnt <= w_inv_cnt_nxt;
      end
   end

   // Next-state logic; overlap is only consulted from IDLE so the window cannot be cut short
   always_comb begin
      w_state_nxt   = r_state;
      w_lives_nxt   = r_lives;
      w_inv_cnt_nxt = r_inv_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_tick && w_ovl) begin
               w_state_nxt = S_HIT;
            end
         end
         S_HIT: begin
            if (r_lives <= 3'd1) begin
               w_lives_nxt = 3'd0;
               w_state_nxt = S_DEAD;
            end else begin
               w_lives_nxt   = r_lives - 3'd1;
               w_inv_cnt_nxt = 8'd0;
               w_state_nxt   = S_INVULN;
            end
         end
         S_INVULN: begin
            if (w_tick) begin
               if (r_inv_cnt == c_INV_LAST) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_inv_cnt_nxt = r_inv_cnt + 8'd1;
               end
            end
         end
         S_DEAD: begin
            w_state_nxt = S_DEAD;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Flags decode straight from registered state so they never glitch
   assign bus.mario_hit = (r_state == S_HIT);
   assign bus.invuln    = (r_state == S_INVULN);
   assign bus.game_over = (r_state == S_DEAD);
   assign bus.blink     = (r_state == S_INVULN) & r_inv_cnt[3];
   assign bus.lives     = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_piranha_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_piranha_hit_ctrl
// Brief    : Directed vector table plus hand-written window/death/reset
//            sequences for piranha_hit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piranha_hit_ctrl;

   logic Clk;
   logic Reset;
   logic frame_clk;

   piranha_hit_ctrl_if bus ();

   piranha_hit_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .bus       (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp;
   int n_err;
   int hit_cnt;

   // Count mario_hit pulses, sampled on the falling edge
   initial hit_cnt = 0;
   always @(negedge Clk) begin
      if (bus.mario_hit === 1'b1) hit_cnt = hit_cnt + 1;
   end

   typedef struct {
      logic [9:0] mx;
      logic [9:0] my;
      logic [9:0] px;
      logic [9:0] py;
      logic       health;
      logic [2:0] lvl;
      logic [2:0] plvl;
      int         exp_hits;
      int         exp_lives;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_pos(input logic [9:0] mx, input logic [9:0] my,
                          input logic [9:0] px, input logic [9:0] py,
                          input logic h, input logic [2:0] l, input logic [2:0] pl);
      bus.mario_x           = mx;
      bus.mario_y           = my;
      bus.piranha_X_Pos     = px;
      bus.piranha_Y_Pos     = py;
      bus.piranha_health    = h;
      bus.level_num         = l;
      bus.piranha_level_num = pl;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   // One frame_clk period: rises on a falling Clk edge, high 4 cycles, low 4 cycles
   task automatic frame();
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   int base;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      Reset     = 1'b0;
      frame_clk = 1'b0;
      set_pos(10'd0, 10'd0, 10'd500, 10'd300, 1'b1, 3'd0, 3'd0);

      //            mx   my   px   py  h  lvl plvl hits lives
      vecs[0]  = '{10'd100, 10'd435, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 1, 2};
      vecs[1]  = '{10'd117, 10'd435, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 1, 2};
      vecs[2]  = '{10'd118, 10'd435, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 0, 3};
      vecs[3]  = '{10'd83,  10'd435, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 1, 2};
      vecs[4]  = '{10'd82,  10'd435, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 0, 3};
      vecs[5]  = '{10'd100, 10'd469, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 1, 2};
      vecs[6]  = '{10'd100, 10'd470, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 0, 3};
      vecs[7]  = '{10'd100, 10'd401, 10'd100, 10'd435, 1'b1, 3'd1, 3'd1, 1, 2};
      vecs[8]  = '{10'd800, 10'd435, 10'd800, 10'd435, 1'b1, 3'd1, 3'd1, 0, 3};
      vecs[9]  = '{10'd100, 10'd435, 10'd100, 10'd435, 1'b0, 3'd1, 3'd1, 0, 3};
      vecs[10] = '{10'd100, 10'd435, 10'd100, 10'd435, 1'b1, 3'd2, 3'd1, 0, 3};
      vecs[11] = '{10'd0,   10'd435, 10'd1023,10'd435, 1'b1, 3'd1, 3'd1, 0, 3};

      // T1: reset state and ten quiet frames
      repeat (3) @(negedge Clk);
      check("reset_lives", int'(bus.lives), 3);
      check("reset_flags", int'({bus.mario_hit, bus.invuln, bus.blink, bus.game_over}), 0);
      Reset = 1'b1;
      base = hit_cnt;
      for (int i = 0; i < 10; i++) frame();
      check("quiet_hits", hit_cnt - base, 0);
      check("quiet_lives", int'(bus.lives), 3);

      // T4: vector table, one frame per vector from a fresh reset
      foreach (vecs[i]) begin
         do_reset();
         set_pos(vecs[i].mx, vecs[i].my, vecs[i].px, vecs[i].py,
                 vecs[i].health, vecs[i].lvl, vecs[i].plvl);
         base = hit_cnt;
         frame();
         check($sformatf("vec%0d_hits", i), hit_cnt - base, vecs[i].exp_hits);
         check($sformatf("vec%0d_lives", i), int'(bus.lives), vecs[i].exp_lives);
         check($sformatf("vec%0d_invuln", i), int'(bus.invuln), vecs[i].exp_hits);
      end

      // Overlap held without any frame tick never hits
      do_reset();
      set_pos(10'd100, 10'd435, 10'd100, 10'd435, 1'b1, 3'd0, 3'd0);
      base = hit_cnt;
      repeat (40) @(negedge Clk);
      check("no_tick_hits", hit_cnt - base, 0);

      // T2/T3/T5: hit, full window with room change, re-hit, death
      frame();
      check("t2_hits", hit_cnt - base, 1);
      check("t2_lives", int'(bus.lives), 2);
      check("t2_invuln", int'(bus.invuln), 1);
      for (int i = 1; i <= 119; i++) begin
         bus.level_num = (i >= 40 && i < 60) ? 3'd5 : 3'd0;
         frame();
         if (i == 8)  check("blink_on", int'(bus.blink), 1);
         if (i == 16) check("blink_off", int'(bus.blink), 0);
      end
      check("t3_window_hits", hit_cnt - base, 1);
      check("t3_window_invuln", int'(bus.invuln), 1);
      frame();
      check("t3_end_invuln", int'(bus.invuln), 0);
      check("t3_end_hits", hit_cnt - base, 1);
      frame();
      check("t3_rehit_hits", hit_cnt - base, 2);
      check("t3_rehit_lives", int'(bus.lives), 1);
      for (int i = 0; i < 120; i++) frame();
      check("t5_idle_again", int'(bus.invuln), 0);
      frame();
      check("t5_hits", hit_cnt - base, 3);
      check("t5_lives", int'(bus.lives), 0);
      check("t5_game_over", int'(bus.game_over), 1);
      check("t5_dead_invuln", int'(bus.invuln), 0);
      for (int i = 0; i < 50; i++) frame();
      check("t5_sticky_go", int'(bus.game_over), 1);
      check("t5_sticky_lives", int'(bus.lives), 0);
      check("t5_sticky_hits", hit_cnt - base, 3);
      do_reset();
      check("t5_reset_lives", int'(bus.lives), 3);
      check("t5_reset_go", int'(bus.game_over), 0);

      // T6: asynchronous reset in the middle of the window at a random Clk phase
      frame();
      check("t6_pre_invuln", int'(bus.invuln), 1);
      repeat (5) frame();
      @(posedge Clk);
      #($urandom_range(1, 8));
      Reset = 1'b0;
      #1;
      check("t6_lives", int'(bus.lives), 3);
      check("t6_flags", int'({bus.mario_hit, bus.invuln, bus.blink, bus.game_over}), 0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
